// File: rtl/iir_pkg.sv
// Shared constants for the 2-slow IIR front end: Q4.3 sample format and slot encoding.
package iir_pkg;

    localparam int DATA_W = 8;
    localparam int FRAC_W = 3;

    localparam logic SLOT_CH1 = 1'b0;
    localparam logic SLOT_CH2 = 1'b1;

endpackage

// File: rtl/iir_2slow_interleaver_fifo.sv
// sample_fifo: per-channel sample buffer, show-ahead read (dout valid whenever !empty).
// Latency: a word pushed at edge k is readable from edge k+1; no write-through bypass.
// Backpressure: push ignored while full, pop ignored while empty; full/empty from the wrap-bit compare.
module sample_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [PW-1:0]     count;

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign count = wptr - rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (count == '0);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + PW'(1);
            if (pop && !empty)
                rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/iir_2slow_interleaver.sv
// Merges two buffered Q4.3 streams into one alternating stream: ch1 in even slots, ch2 in odd slots.
// Latency: registered output, 1-2 cycles from push; optional counters under IIR_ILV_UNDERRUN_CNT_EN.
// Backpressure: inputs see !full; the output never stalls, an empty slot repeats the last sample.
module iir_2slow_interleaver
    import iir_pkg::*;
#(
    parameter int DATA_W     = iir_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x1_data,
    input  logic              x1_valid,
    output logic              x1_ready,
    input  logic [DATA_W-1:0] x2_data,
    input  logic              x2_valid,
    output logic              x2_ready,
    input  logic              en,
    input  logic              clr_underrun,
    output logic [DATA_W-1:0] x_out,
    output logic              slot,
    output logic              out_valid,
    output logic [1:0]        underrun
`ifdef IIR_ILV_UNDERRUN_CNT_EN
    ,
    output logic [7:0]        underrun_cnt1,
    output logic [7:0]        underrun_cnt2
`endif
);

    logic              full1, empty1, full2, empty2;
    logic [DATA_W-1:0] dout1, dout2;
    logic [DATA_W-1:0] last1, last2;
    logic              slot_cnt;
    logic              pop1, pop2;
    logic [1:0]        new_ur;
    logic [DATA_W-1:0] nxt_x;

    assign x1_ready = ~full1;
    assign x2_ready = ~full2;

    sample_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (x1_valid & x1_ready),
        .din   (x1_data),
        .pop   (pop1),
        .dout  (dout1),
        .full  (full1),
        .empty (empty1)
    );

    sample_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo2 (
        .clk   (clk),
        .rst   (rst),
        .push  (x2_valid & x2_ready),
        .din   (x2_data),
        .pop   (pop2),
        .dout  (dout2),
        .full  (full2),
        .empty (empty2)
    );

    // Slot selection: pop the owning channel, or repeat its last sample and flag an underrun.
    always_comb begin
        pop1   = 1'b0;
        pop2   = 1'b0;
        new_ur = 2'b00;
        nxt_x  = '0;
        if (en) begin
            if (slot_cnt == SLOT_CH1) begin
                if (!empty1) begin
                    pop1  = 1'b1;
                    nxt_x = dout1;
                end else begin
                    nxt_x     = last1;
                    new_ur[0] = 1'b1;
                end
            end else begin
                if (!empty2) begin
                    pop2  = 1'b1;
                    nxt_x = dout2;
                end else begin
                    nxt_x     = last2;
                    new_ur[1] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_out     <= '0;
            slot      <= SLOT_CH1;
            out_valid <= 1'b0;
            slot_cnt  <= SLOT_CH1;
            last1     <= '0;
            last2     <= '0;
            underrun  <= 2'b00;
        end else begin
            x_out     <= nxt_x;
            out_valid <= en;
            slot      <= en ? slot_cnt : SLOT_CH1;
            slot_cnt  <= en ? ~slot_cnt : SLOT_CH1;
            if (pop1)
                last1 <= dout1;
            if (pop2)
                last2 <= dout2;
            // A fresh underrun survives a simultaneous clear.
            underrun  <= clr_underrun ? new_ur : (underrun | new_ur);
        end
    end

`ifdef IIR_ILV_UNDERRUN_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_cnt1 <= 8'd0;
            underrun_cnt2 <= 8'd0;
        end else begin
            if (clr_underrun)
                underrun_cnt1 <= {7'd0, new_ur[0]};
            else if (new_ur[0] && underrun_cnt1 != 8'hFF)
                underrun_cnt1 <= underrun_cnt1 + 8'd1;
            if (clr_underrun)
                underrun_cnt2 <= {7'd0, new_ur[1]};
            else if (new_ur[1] && underrun_cnt2 != 8'hFF)
                underrun_cnt2 <= underrun_cnt2 + 8'd1;
        end
    end
`endif

endmodule
